// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage SRAM access unit.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned BASE_ADDR_DEF = 1024;
    localparam int unsigned SRAM_DW       = 16;

endpackage

// File: rtl/mem_access_unit_sram_half_access.sv
// One half-word SRAM access: wait counter, write strobes and read-sample timing.
module sram_half_access
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned WAIT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               active,
    input  logic               write,
    input  logic [SRAM_DW-1:0] wdata,
    output logic               last_c,
    output logic               sample_c,
    output logic               we_n_c,
    output logic               dq_oe_c,
    output logic [SRAM_DW-1:0] dq_out_c
);

    localparam int unsigned CNT_W = (WAIT > 1) ? $clog2(WAIT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             drive_c;

    assign last_c   = active && (cnt_q == CNT_W'(WAIT - 1));
    assign sample_c = last_c && !write;
    assign drive_c  = active && write;
    assign we_n_c   = !drive_c;
    assign dq_oe_c  = drive_c;
    assign dq_out_c = drive_c ? wdata : '0;

    // Counter restarts at every half boundary so LO and HI each get WAIT cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (!active || last_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: 32-bit loads/stores as two 16-bit SRAM accesses, plus the MEM/WB register.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned BASE_ADDR = BASE_ADDR_DEF,
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned WAIT      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               WB_EN,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        ALU_Res,
    input  logic [31:0]        Val_Rm,
    input  logic [3:0]         Dest,
    output logic               ready,
    output logic [ADDR_W-1:0]  SRAM_ADDR,
    output logic [SRAM_DW-1:0] SRAM_DQ_out,
    output logic               SRAM_DQ_oe,
    input  logic [SRAM_DW-1:0] SRAM_DQ_in,
    output logic               SRAM_WE_N,
    output logic               WB_EN_out,
    output logic               MEM_R_EN_out,
    output logic [31:0]        ALU_Res_out,
    output logic [31:0]        Mem_Data_out,
    output logic [3:0]         Dest_out
);

    state_t state_q, state_d;

    logic               rd_q;
    logic               wb_q;
    logic [31:0]        alu_q;
    logic [31:0]        wdata_q;
    logic [3:0]         dest_q;
    logic [ADDR_W-1:0]  lo_addr_q;
    logic [SRAM_DW-1:0] data_lo_q;
    logic [SRAM_DW-1:0] data_hi_q;

    logic               req_c;
    logic               active_c;
    logic               is_hi_c;
    logic               last_c;
    logic               sample_c;
    logic [ADDR_W-1:0]  lo_addr_c;
    logic [SRAM_DW-1:0] half_wdata_c;

    assign req_c        = MEM_R_EN || MEM_W_EN;
    assign active_c     = (state_q == LO) || (state_q == HI);
    assign is_hi_c      = (state_q == HI);
    // Word offset from the SRAM base, doubled into a half-word address; byte bits dropped.
    assign lo_addr_c    = ADDR_W'(((ALU_Res - 32'(BASE_ADDR)) >> 2) << 1);
    assign half_wdata_c = is_hi_c ? wdata_q[31:16] : wdata_q[15:0];
    assign SRAM_ADDR    = active_c ? (lo_addr_q | ADDR_W'(is_hi_c)) : '0;

    sram_half_access #(
        .WAIT (WAIT)
    ) u_half (
        .clk      (clk),
        .rst      (rst),
        .active   (active_c),
        .write    (!rd_q),
        .wdata    (half_wdata_c),
        .last_c   (last_c),
        .sample_c (sample_c),
        .we_n_c   (SRAM_WE_N),
        .dq_oe_c  (SRAM_DQ_oe),
        .dq_out_c (SRAM_DQ_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencing: one request walks LO -> HI -> DONE and always returns through IDLE.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            IDLE: begin
                ready = !req_c;
                if (req_c) begin
                    state_d = LO;
                end
            end
            LO: begin
                if (last_c) begin
                    state_d = HI;
                end
            end
            HI: begin
                if (last_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture and read-data sampling; a read wins when both enables are set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q      <= 1'b0;
            wb_q      <= 1'b0;
            alu_q     <= '0;
            wdata_q   <= '0;
            dest_q    <= '0;
            lo_addr_q <= '0;
            data_lo_q <= '0;
            data_hi_q <= '0;
        end else begin
            if ((state_q == IDLE) && req_c) begin
                rd_q      <= MEM_R_EN;
                wb_q      <= WB_EN;
                alu_q     <= ALU_Res;
                wdata_q   <= Val_Rm;
                dest_q    <= Dest;
                lo_addr_q <= lo_addr_c;
            end
            if (sample_c && !is_hi_c) begin
                data_lo_q <= SRAM_DQ_in;
            end
            if (sample_c && is_hi_c) begin
                data_hi_q <= SRAM_DQ_in;
            end
        end
    end

    // MEM/WB register: pass-through when idle, latched result in DONE, bubble while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WB_EN_out    <= 1'b0;
            MEM_R_EN_out <= 1'b0;
            ALU_Res_out  <= '0;
            Mem_Data_out <= '0;
            Dest_out     <= '0;
        end else if (ready && (state_q == IDLE)) begin
            WB_EN_out    <= WB_EN;
            MEM_R_EN_out <= 1'b0;
            ALU_Res_out  <= ALU_Res;
            Mem_Data_out <= '0;
            Dest_out     <= Dest;
        end else if (ready) begin
            WB_EN_out    <= wb_q;
            MEM_R_EN_out <= rd_q;
            ALU_Res_out  <= alu_q;
            Mem_Data_out <= rd_q ? {data_hi_q, data_lo_q} : '0;
            Dest_out     <= dest_q;
        end else begin
            WB_EN_out    <= 1'b0;
            MEM_R_EN_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural 16-bit SRAM.
module tb_mem_access_unit;

    localparam int unsigned W = 2;

    typedef struct {
        logic        wb;
        logic        mr;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [3:0]  dest;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        WB_EN, MEM_R_EN, MEM_W_EN;
    logic [31:0] ALU_Res, Val_Rm;
    logic [3:0]  Dest;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_out, SRAM_DQ_in;
    logic        SRAM_DQ_oe, SRAM_WE_N;
    logic        WB_EN_out, MEM_R_EN_out;
    logic [31:0] ALU_Res_out, Mem_Data_out;
    logic [3:0]  Dest_out;

    int checks = 0;
    int errors = 0;

    res_t        exp_q[$];
    logic [17:0] obs_addr[$];
    logic [1:0]  obs_ctl[$];
    logic [15:0] obs_dq[$];
    logic        obs_wb[$];

    logic [15:0] sram [0:63];
    int          we_cycles = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!SRAM_WE_N) begin
            sram[SRAM_ADDR[5:0]] <= SRAM_DQ_out;
            we_cycles            <= we_cycles + 1;
        end
    end
    assign SRAM_DQ_in = sram[SRAM_ADDR[5:0]];

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .Dest(Dest),
        .ready(ready),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_oe(SRAM_DQ_oe),
        .SRAM_DQ_in(SRAM_DQ_in), .SRAM_WE_N(SRAM_WE_N),
        .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out), .ALU_Res_out(ALU_Res_out),
        .Mem_Data_out(Mem_Data_out), .Dest_out(Dest_out)
    );

    task automatic drive(input logic wb, input logic r, input logic w,
                         input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dest);
        WB_EN = wb; MEM_R_EN = r; MEM_W_EN = w; ALU_Res = alu; Val_Rm = val; Dest = dest;
    endtask

    // Presents one instruction, records SRAM pins per cycle, returns in the first ready=1 cycle.
    task automatic issue(input logic wb, input logic r, input logic w,
                         input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dest,
                         output int stall);
        obs_addr.delete(); obs_ctl.delete(); obs_dq.delete(); obs_wb.delete();
        @(negedge clk);
        drive(wb, r, w, alu, val, dest);
        stall = 0;
        for (int c = 0; c < 64; c++) begin
            if (c > 0) begin
                ALU_Res = $urandom; Val_Rm = $urandom; Dest = 4'($urandom);
            end
            #1;
            obs_addr.push_back(SRAM_ADDR);
            obs_ctl.push_back({SRAM_WE_N, SRAM_DQ_oe});
            obs_dq.push_back(SRAM_DQ_out);
            obs_wb.push_back(WB_EN_out);
            if (ready) break;
            stall++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({SRAM_WE_N, SRAM_DQ_oe, SRAM_ADDR, SRAM_DQ_out} !== {1'b1, 1'b0, 18'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_sram: got we_n=%b oe=%b addr=%0d dq=%h", SRAM_WE_N, SRAM_DQ_oe, SRAM_ADDR, SRAM_DQ_out);
        end
        checks++;
        if ({WB_EN_out, MEM_R_EN_out, ALU_Res_out, Mem_Data_out, Dest_out} !== 70'd0) begin
            errors++;
            $display("FAIL reset_memwb: got wb=%b mr=%b alu=%h mem=%h dest=%h, want all 0",
                     WB_EN_out, MEM_R_EN_out, ALU_Res_out, Mem_Data_out, Dest_out);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", ready);
        end
    endtask

    task automatic test_non_mem();
        int   stall;
        res_t e;
        exp_q.push_back('{wb: 1'b1, mr: 1'b0, alu: 32'h12345678, mem: 32'h0, dest: 4'd3});
        issue(1, 0, 0, 32'h12345678, 32'h0, 4'd3, stall);
        checks++;
        if (stall !== 0) begin
            errors++;
            $display("FAIL non_mem_stall: got %0d want 0", stall);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if ({WB_EN_out, MEM_R_EN_out, ALU_Res_out, Mem_Data_out, Dest_out} !== {e.wb, e.mr, e.alu, e.mem, e.dest}) begin
            errors++;
            $display("FAIL non_mem_result: got wb=%b mr=%b alu=%h mem=%h dest=%h want wb=%b mr=%b alu=%h mem=%h dest=%h",
                     WB_EN_out, MEM_R_EN_out, ALU_Res_out, Mem_Data_out, Dest_out, e.wb, e.mr, e.alu, e.mem, e.dest);
        end
    endtask

    task automatic test_reset_mid_write();
        int we0;
        int stall;
        res_t e;
        @(negedge clk);
        drive(0, 0, 1, 32'd1040, 32'hCAFEF00D, 4'd1);
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_req_ready: got %b want 0", ready);
        end
        @(negedge clk); #1;
        checks++;
        if ({SRAM_WE_N, SRAM_DQ_oe, SRAM_ADDR, SRAM_DQ_out} !== {1'b0, 1'b1, 18'd8, 16'hF00D}) begin
            errors++;
            $display("FAIL midrst_lo: got we_n=%b oe=%b addr=%0d dq=%h want 0 1 8 f00d", SRAM_WE_N, SRAM_DQ_oe, SRAM_ADDR, SRAM_DQ_out);
        end
        we0 = we_cycles;
        rst = 1'b0;
        #1;
        checks++;
        if ({SRAM_WE_N, SRAM_DQ_oe, SRAM_ADDR, SRAM_DQ_out} !== {1'b1, 1'b0, 18'd0, 16'd0}) begin
            errors++;
            $display("FAIL midrst_sram: got we_n=%b oe=%b addr=%0d dq=%h want 1 0 0 0", SRAM_WE_N, SRAM_DQ_oe, SRAM_ADDR, SRAM_DQ_out);
        end
        checks++;
        if ({WB_EN_out, MEM_R_EN_out, ALU_Res_out, Mem_Data_out, Dest_out} !== 70'd0) begin
            errors++;
            $display("FAIL midrst_memwb: got wb=%b mr=%b alu=%h mem=%h dest=%h want all 0",
                     WB_EN_out, MEM_R_EN_out, ALU_Res_out, Mem_Data_out, Dest_out);
        end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready: got %b want 1", ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (we_cycles !== we0) begin
            errors++;
            $display("FAIL midrst_no_write: got %0d strobe cycles want %0d", we_cycles, we0);
        end
        exp_q.push_back('{wb: 1'b1, mr: 1'b0, alu: 32'h0BADF00D, mem: 32'h0, dest: 4'd4});
        issue(1, 0, 0, 32'h0BADF00D, 32'h0, 4'd4, stall);
        checks++;
        if (stall !== 0) begin
            errors++;
            $display("FAIL midrst_idle_stall: got %0d want 0", stall);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if ({WB_EN_out, ALU_Res_out, Dest_out} !== {e.wb, e.alu, e.dest}) begin
            errors++;
            $display("FAIL midrst_idle_result: got wb=%b alu=%h dest=%h want wb=%b alu=%h dest=%h",
                     WB_EN_out, ALU_Res_out, Dest_out, e.wb, e.alu, e.dest);
        end
    endtask

    // Store of val at alu, checking both halves on the pins; lo/hi are the expected half addresses.
    task automatic test_store(input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dest,
                              input logic [17:0] lo);
        int          stall;
        res_t        e;
        logic [17:0] ea;
        logic [15:0] ed;
        exp_q.push_back('{wb: 1'b0, mr: 1'b0, alu: alu, mem: 32'h0, dest: dest});
        issue(0, 0, 1, alu, val, dest, stall);
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (stall !== 2 * W + 1) begin
            errors++;
            $display("FAIL store_stall: got %0d want %0d", stall, 2 * W + 1);
        end
        for (int c = 0; c < obs_ctl.size(); c++) begin
            checks++;
            if (c >= 1 && c <= 2 * W) begin
                ea = (c <= W) ? lo : lo + 18'd1;
                ed = (c <= W) ? val[15:0] : val[31:16];
                if ({obs_ctl[c], obs_addr[c], obs_dq[c]} !== {2'b01, ea, ed}) begin
                    errors++;
                    $display("FAIL store_pins c%0d: got ctl=%b addr=%0d dq=%h want ctl=01 addr=%0d dq=%h",
                             c, obs_ctl[c], obs_addr[c], obs_dq[c], ea, ed);
                end
            end else if (obs_ctl[c] !== 2'b10) begin
                errors++;
                $display("FAIL store_idle_pins c%0d: got ctl=%b want 10", c, obs_ctl[c]);
            end
            if (c >= 1) begin
                checks++;
                if (obs_wb[c] !== 1'b0) begin
                    errors++;
                    $display("FAIL store_bubble c%0d: got WB_EN_out=%b want 0", c, obs_wb[c]);
                end
            end
        end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if ({WB_EN_out, MEM_R_EN_out, ALU_Res_out, Mem_Data_out, Dest_out} !== {e.wb, e.mr, e.alu, e.mem, e.dest}) begin
            errors++;
            $display("FAIL store_result: got wb=%b mr=%b alu=%h mem=%h dest=%h want wb=%b mr=%b alu=%h mem=%h dest=%h",
                     WB_EN_out, MEM_R_EN_out, ALU_Res_out, Mem_Data_out, Dest_out, e.wb, e.mr, e.alu, e.mem, e.dest);
        end
    endtask

    // Load (w also set when exercising read priority); expects data and read-only pins.
    task automatic test_load(input logic w, input logic [31:0] alu, input logic [3:0] dest,
                             input logic [17:0] lo, input logic [31:0] data);
        int          stall;
        res_t        e;
        logic [17:0] ea;
        exp_q.push_back('{wb: 1'b1, mr: 1'b1, alu: alu, mem: data, dest: dest});
        issue(1, 1, w, alu, 32'hFFFF0000, dest, stall);
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (stall !== 2 * W + 1) begin
            errors++;
            $display("FAIL load_stall: got %0d want %0d", stall, 2 * W + 1);
        end
        for (int c = 0; c < obs_ctl.size(); c++) begin
            checks++;
            ea = (c <= W) ? lo : lo + 18'd1;
            if (obs_ctl[c] !== 2'b10 || (c >= 1 && c <= 2 * W && obs_addr[c] !== ea)) begin
                errors++;
                $display("FAIL load_pins c%0d: got ctl=%b addr=%0d want ctl=10 addr=%0d", c, obs_ctl[c], obs_addr[c], ea);
            end
        end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if ({WB_EN_out, MEM_R_EN_out, ALU_Res_out, Mem_Data_out, Dest_out} !== {e.wb, e.mr, e.alu, e.mem, e.dest}) begin
            errors++;
            $display("FAIL load_result: got wb=%b mr=%b alu=%h mem=%h dest=%h want wb=%b mr=%b alu=%h mem=%h dest=%h",
                     WB_EN_out, MEM_R_EN_out, ALU_Res_out, Mem_Data_out, Dest_out, e.wb, e.mr, e.alu, e.mem, e.dest);
        end
    endtask

    task automatic test_back_to_back();
        int   stall;
        res_t e;
        exp_q.push_back('{wb: 1'b1, mr: 1'b1, alu: 32'd1024, mem: 32'h22221111, dest: 4'd9});
        exp_q.push_back('{wb: 1'b1, mr: 1'b0, alu: 32'hCAFE0001, mem: 32'h0, dest: 4'd10});
        issue(1, 1, 0, 32'd1024, 32'h0, 4'd9, stall);
        drive(1, 0, 0, 32'hCAFE0001, 32'h0, 4'd10);
        checks++;
        if (stall !== 2 * W + 1) begin
            errors++;
            $display("FAIL b2b_stall: got %0d want %0d", stall, 2 * W + 1);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if ({WB_EN_out, MEM_R_EN_out, ALU_Res_out, Mem_Data_out, Dest_out} !== {e.wb, e.mr, e.alu, e.mem, e.dest}) begin
            errors++;
            $display("FAIL b2b_load: got wb=%b mr=%b alu=%h mem=%h dest=%h want wb=%b mr=%b alu=%h mem=%h dest=%h",
                     WB_EN_out, MEM_R_EN_out, ALU_Res_out, Mem_Data_out, Dest_out, e.wb, e.mr, e.alu, e.mem, e.dest);
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_ready: got %b want 1", ready);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if ({WB_EN_out, MEM_R_EN_out, ALU_Res_out, Mem_Data_out, Dest_out} !== {e.wb, e.mr, e.alu, e.mem, e.dest}) begin
            errors++;
            $display("FAIL b2b_non_mem: got wb=%b mr=%b alu=%h mem=%h dest=%h want wb=%b mr=%b alu=%h mem=%h dest=%h",
                     WB_EN_out, MEM_R_EN_out, ALU_Res_out, Mem_Data_out, Dest_out, e.wb, e.mr, e.alu, e.mem, e.dest);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_non_mem();
        test_reset_mid_write();
        test_store(32'd1032, 32'hDEADBEEF, 4'd5, 18'd4);
        test_load(1'b0, 32'd1032, 4'd7, 18'd4, 32'hDEADBEEF);
        test_store(32'd1024, 32'h22221111, 4'd2, 18'd0);
        test_load(1'b1, 32'd1024, 4'd2, 18'd0, 32'h22221111);
        test_back_to_back();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EXE/MEM pipeline register outputs (WB_EN, MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, Dest).
- Performs 32-bit data loads and stores on an external 16-bit SRAM as two half-word accesses.
- Drives `ready` low to freeze the upstream pipeline while an access is in flight.
- Holds the MEM/WB register, which feeds the WB stage.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- ADDR_W, 18: SRAM half-word address width.
- WAIT, 2: clock cycles per half-word access; must be ≥1.

Ports:
- clk  in  1: clock; all state updates on the rising edge.
- rst  in  1: asynchronous, active-low reset.
- WB_EN  in  1: write-back enable from EXE/MEM.
- MEM_R_EN  in  1: load request.
- MEM_W_EN  in  1: store request.
- ALU_Res  in  32: effective byte address, or ALU result for non-memory instructions.
- Val_Rm  in  32: store data.
- Dest  in  4: destination register.
- ready  out  1: 0 freezes all upstream stages.
- SRAM_ADDR  out  ADDR_W: SRAM half-word address.
- SRAM_DQ_out  out  16: write data.
- SRAM_DQ_oe  out  1: write-data drive enable.
- SRAM_DQ_in  in  16: read data.
- SRAM_WE_N  out  1: active-low write strobe.
- WB_EN_out  out  1: MEM/WB register field.
- MEM_R_EN_out  out  1: MEM/WB register field.
- ALU_Res_out  out  32: MEM/WB register field.
- Mem_Data_out  out  32: MEM/WB register field.
- Dest_out  out  4: MEM/WB register field.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; counter = 0; latched data = 0.
  - SRAM_WE_N=1, SRAM_DQ_oe=0, SRAM_ADDR=0, SRAM_DQ_out=0.
  - All MEM/WB outputs = 0.
  - Applies mid-access: the access is abandoned and no partial write is completed after reset release.
- Address mapping:
  - off = ALU_Res − BASE_ADDR (32-bit, wrap on underflow); word = off[31:2].
  - Low half address = {word, 0}; high half address = {word, 1}; both truncated to ADDR_W LSBs.
  - off[1:0] is ignored.
- Request priority: a request exists when MEM_R_EN | MEM_W_EN. If both are 1, perform a read; the write is suppressed.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE:
    - On a request: latch ALU_Res, Val_Rm, Dest, WB_EN and access type; cnt=0; go to LO.
    - No request: stay in IDLE.
  - LO:
    - SRAM_ADDR = low-half address.
    - Write: SRAM_DQ_out=Val_Rm[15:0], SRAM_DQ_oe=1, SRAM_WE_N=0 for all WAIT cycles.
    - Read: sample SRAM_DQ_in into data_lo on the last (WAIT-th) cycle.
    - After WAIT cycles go to HI with cnt=0.
  - HI: same as LO using the high-half address, Val_Rm[31:16] and data_hi. After WAIT cycles go to DONE.
  - DONE: one cycle, then go to IDLE.
  - SRAM_WE_N=1 and SRAM_DQ_oe=0 in IDLE and DONE.
- ready (combinational):
  - 1 in DONE.
  - 1 in IDLE with no request.
  - 0 in IDLE with a request, and 0 in LO and HI.
  - Stall length per access = 2*WAIT+1 cycles of ready=0 including the request cycle; access completes 2*WAIT+1 cycles after the request is seen.
- MEM/WB register, updated every clock edge:
  - ready=1 in IDLE: WB_EN_out=WB_EN, MEM_R_EN_out=0, ALU_Res_out=ALU_Res, Dest_out=Dest, Mem_Data_out=0.
  - ready=1 in DONE: fields taken from the latched copy; MEM_R_EN_out = 1 for a read; Mem_Data_out = {data_hi, data_lo} for a read, 0 for a write; WB_EN_out = latched WB_EN.
  - ready=0: bubble. WB_EN_out=0 and MEM_R_EN_out=0; other fields hold their values.
- Back-to-back accesses: the next instruction is presented in the DONE cycle and is seen in IDLE on the following cycle. There is no IDLE→LO bypass from DONE.
- Upstream inputs are don't-care while in LO, HI and DONE (latched copies are used).

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/LO/HI/DONE, 2 bits).
  - BASE_ADDR default.
  - The SRAM data width constant (16).
- One natural sub-module: sram_half_access, containing the wait counter plus WE/OE/sample timing for a single half-word access. The top FSM instantiates it once and sequences LO then HI.
- The MEM/WB register stays in the top module.

Test Plan:
- Reset mid-write: assert rst=0 during the LO state of a store → SRAM_WE_N=1 and SRAM_DQ_oe=0 immediately; all outputs 0; after release ready=1 and the FSM is in IDLE.
- Non-memory instruction: WB_EN=1, ALU_Res=0x12345678, Dest=3, no memory enables → ready stays 1; next cycle WB_EN_out=1, ALU_Res_out=0x12345678, Dest_out=3, Mem_Data_out=0.
- Store, WAIT=2: ALU_Res=1032, Val_Rm=0xDEADBEEF →
  - SRAM_ADDR=4 with DQ=0xBEEF and WE_N=0 for 2 cycles.
  - Then SRAM_ADDR=5 with DQ=0xDEAD for 2 cycles.
  - ready=0 for 5 cycles; WB_EN_out=0 throughout.
- Load after that store: the SRAM model returns 0xBEEF at address 4 and 0xDEAD at address 5 → Mem_Data_out=0xDEADBEEF, MEM_R_EN_out=1, Dest_out taken from the latch, 5-cycle stall.
- Both enables set, with ALU_Res=1024 → read only; SRAM_WE_N stays 1 throughout; addresses 0 then 1.
- Back-to-back load then non-memory instruction → after DONE, the non-memory result appears on the next cycle with no extra bubble beyond the one IDLE cycle.
